// File: rtl/core_3do_pkg.sv
// Shared Wishbone burst encodings and the memory-responder state set for core_3do.
// The CTI/BTE codes follow Wishbone B4 cycle-type and burst-type identifiers.
package core_3do_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK,
    ST_ERR,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/wb_burst_addr.sv
// Next word address for a Wishbone burst: linear increments all of addr, wrap modes
// increment only the low log2(beats) bits of the word index. Purely combinational.
module wb_burst_addr
  import core_3do_pkg::*;
(
  input  logic [29:0] addr,
  input  logic [1:0]  bte,
  output logic [29:0] next_addr
);

  always_comb begin
    next_addr = addr + 30'd1;
    case (bte)
      BTE_WRAP4:  next_addr = {addr[29:2], addr[1:0] + 2'd1};
      BTE_WRAP8:  next_addr = {addr[29:3], addr[2:0] + 3'd1};
      BTE_WRAP16: next_addr = {addr[29:4], addr[3:0] + 4'd1};
      default:    next_addr = addr + 30'd1;
    endcase
  end

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B4 responder mapping CPU cycles in one address region onto a req/ready memory port.
// Ack two cycles after the stb sample at zero wait; mem_ready stalls extend REQ up to TIMEOUT.
module wb_mem_responder
  import core_3do_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFE0_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic [2:0]  i_wb_cti,
  input  logic [1:0]  i_wb_bte,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_dat,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        o_busy
);

  localparam logic [9:0] TMO = 10'(TIMEOUT);

  state_t      state;
  logic [29:0] waddr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        we;
  logic        wr_req;
  logic        relatch;
  logic        aborted;
  logic [9:0]  cnt;

  logic [29:0] next_waddr;
  logic [3:0]  cur_sel;
  logic [31:0] cur_dat;
  logic        hit;
  logic        skip;
  logic        gone;

  wb_burst_addr u_burst_addr (
    .addr      (waddr),
    .bte       (bte),
    .next_addr (next_waddr)
  );

  // On the first REQ cycle of a continued beat the master has already advanced
  // dat/sel, so the memory side sees the bus directly until they are latched.
  assign cur_sel   = relatch ? i_wb_sel : sel;
  assign cur_dat   = relatch ? i_wb_dat : dat;
  assign hit       = (i_wb_adr & ADDR_MASK) == ADDR_BASE;
  assign skip      = we && (cur_sel == 4'd0);
  assign gone      = aborted || !i_wb_cyc;

  assign mem_addr  = {waddr, 2'b00};
  assign mem_be    = cur_sel;
  assign mem_wdata = cur_dat;
  assign mem_wr    = wr_req && (cur_sel != 4'd0);
  assign o_busy    = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      waddr    <= '0;
      dat      <= '0;
      sel      <= '0;
      cti      <= '0;
      bte      <= '0;
      we       <= 1'b0;
      wr_req   <= 1'b0;
      mem_rd   <= 1'b0;
      relatch  <= 1'b0;
      aborted  <= 1'b0;
      cnt      <= '0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          aborted <= 1'b0;
          if (i_wb_cyc && i_wb_stb) begin
            if (hit) begin
              waddr  <= i_wb_adr[31:2];
              dat    <= i_wb_dat;
              sel    <= i_wb_sel;
              cti    <= i_wb_cti;
              bte    <= i_wb_bte;
              we     <= i_wb_we;
              cnt    <= '0;
              mem_rd <= !i_wb_we;
              wr_req <= i_wb_we;
              state  <= ST_REQ;
            end else begin
              o_wb_err <= 1'b1;
              state    <= ST_ERR;
            end
          end
        end
        ST_REQ: begin
          if (relatch) begin
            dat     <= i_wb_dat;
            sel     <= i_wb_sel;
            cti     <= i_wb_cti;
            relatch <= 1'b0;
          end
          if (!i_wb_cyc) aborted <= 1'b1;
          // Ready is checked before the timeout so a late ready still completes.
          if (mem_ready || skip) begin
            mem_rd <= 1'b0;
            wr_req <= 1'b0;
            if (gone) begin
              state <= ST_DRAIN;
            end else begin
              o_wb_ack <= 1'b1;
              if (!we) o_wb_dat <= mem_rdata;
              state <= ST_ACK;
            end
          end else if (cnt == TMO) begin
            mem_rd <= 1'b0;
            wr_req <= 1'b0;
            if (gone) begin
              state <= ST_DRAIN;
            end else begin
              o_wb_err <= 1'b1;
              state    <= ST_ERR;
            end
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        ST_ACK: begin
          if (cti == CTI_INCR && i_wb_cyc && i_wb_stb) begin
            waddr   <= next_waddr;
            relatch <= 1'b1;
            aborted <= 1'b0;
            cnt     <= '0;
            mem_rd  <= !we;
            wr_req  <= we;
            state   <= ST_REQ;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ERR:   state <= ST_IDLE;
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Randomised Wishbone master plus wait-state memory device, checked against a transaction-level model.
module tb_wb_mem_responder;
  import core_3do_pkg::*;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0] i_wb_adr, i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic [2:0]  i_wb_cti;
  logic [1:0]  i_wb_bte;
  logic        o_wb_ack, o_wb_err, o_busy;
  logic [31:0] o_wb_dat, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_rd, mem_wr, mem_ready;

  wb_mem_responder dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_cti(i_wb_cti), .i_wb_bte(i_wb_bte),
    .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_dat(o_wb_dat),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .o_busy(o_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  acc_t        acc_log [$];
  int          wait_cfg = 0;
  bit          wait_rand = 1'b0;
  int          cur_wait = 0, waited = 0, rd_hi = 0, wr_hi = 0;

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (!ref_mem.exists(a)) ref_mem[a] = seed_word(a);
    return ref_mem[a];
  endfunction

  // Memory device: acts just after each rising edge, answers after cur_wait stalled cycles.
  initial begin
    logic [31:0] a, w;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      mem_ready = 1'b0;
      if (mem_rd) rd_hi++;
      if (mem_wr) wr_hi++;
      if (mem_rd || mem_wr) begin
        if (waited >= cur_wait) begin
          a = mem_addr;
          if (!dev_mem.exists(a)) dev_mem[a] = seed_word(a);
          w = dev_mem[a];
          mem_rdata = w;
          if (mem_wr) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            dev_mem[a] = w;
          end
          acc_log.push_back('{a, mem_wr, mem_be, mem_wdata});
          mem_ready = 1'b1;
          waited = 0;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
        cur_wait = wait_rand ? int'($urandom_range(0, 3)) : wait_cfg;
      end
    end
  end

  // Expected word address of beat k, derived from the burst rules directly.
  function automatic logic [31:0] exp_addr(input logic [31:0] start, input logic [1:0] bte, input int k);
    logic [31:0] s, blk, base;
    s = {start[31:2], 2'b00};
    if (bte == BTE_LINEAR) return s + 32'(4 * k);
    blk  = 32'((2 << bte) * 4);
    base = s & ~(blk - 32'd1);
    return base + ((s - base + 32'(4 * k)) % blk);
  endfunction

  logic [31:0] wdat [16];
  logic [3:0]  wsel [16];
  logic [31:0] rdq  [$];
  int          acks, errs, lat_first, lat_last, lat_err;
  logic [31:0] wrap_seq [4] = '{32'h0C, 32'h00, 32'h04, 32'h08};

  task automatic wb_xfer(input logic [31:0] adr, input bit we, input int n, input bit burst, input logic [1:0] bte);
    int  beat = 0;
    int  cyc_n = 0;
    bit  done = 1'b0;
    acks = 0; errs = 0; lat_first = 0; lat_last = 0; lat_err = 0;
    rdq.delete();
    @(negedge sys_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_adr = adr;
    i_wb_dat = wdat[0]; i_wb_sel = wsel[0]; i_wb_bte = bte;
    i_wb_cti = !burst ? CTI_CLASSIC : (n == 1 ? CTI_EOB : CTI_INCR);
    while (!done) begin
      @(negedge sys_clk);
      cyc_n++;
      if (o_wb_ack) begin
        acks++;
        if (beat == 0) lat_first = cyc_n;
        lat_last = cyc_n;
        if (!we) rdq.push_back(o_wb_dat);
        beat++;
        if (beat >= n) begin
          done = 1'b1;
        end else begin
          i_wb_adr = exp_addr(adr, bte, beat);
          i_wb_dat = wdat[beat];
          i_wb_sel = wsel[beat];
          i_wb_cti = (beat == n - 1) ? CTI_EOB : CTI_INCR;
        end
      end else if (o_wb_err) begin
        errs++;
        lat_err = cyc_n;
        done = 1'b1;
      end
      if (!done && cyc_n >= 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL xfer_bound: no termination within %0d cycles", cyc_n);
        done = 1'b1;
      end
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_cti = CTI_CLASSIC;
    repeat (3) begin
      @(negedge sys_clk);
      if (o_wb_ack) acks++;
      if (o_wb_err) errs++;
    end
  endtask

  // Runs one transaction and compares responses and memory traffic against the model.
  task automatic run_check(input string tag, input logic [31:0] adr, input bit we,
                           input int n, input bit burst, input logic [1:0] bte);
    bit          hit;
    int          ai = 0;
    acc_t        e;
    logic [31:0] a, w, rd;
    hit = (adr & 32'hFFE0_0000) == 32'h0;
    acc_log.delete();
    wb_xfer(adr, we, n, burst, bte);
    if (!hit) begin
      chk({tag, "_err"}, 32'(errs), 32'd1);
      chk({tag, "_ack"}, 32'(acks), 32'd0);
      chk({tag, "_nacc"}, 32'(acc_log.size()), 32'd0);
    end else begin
      chk({tag, "_ack"}, 32'(acks), 32'(n));
      chk({tag, "_err"}, 32'(errs), 32'd0);
      for (int k = 0; k < n; k++) begin
        a = exp_addr(adr, bte, k);
        if (we && wsel[k] == 4'd0) continue;
        e = '{32'hFFFF_FFFF, 1'b1, 4'hF, 32'hFFFF_FFFF};
        if (ai < acc_log.size()) e = acc_log[ai];
        ai++;
        chk($sformatf("%s_addr%0d", tag, k), e.addr, a);
        chk($sformatf("%s_wr%0d", tag, k), 32'(e.wr), 32'(we));
        if (we) begin
          chk($sformatf("%s_be%0d", tag, k), 32'(e.be), 32'(wsel[k]));
          chk($sformatf("%s_wd%0d", tag, k), e.wdata, wdat[k]);
          w = ref_rd(a);
          for (int b = 0; b < 4; b++)
            if (wsel[k][b]) w[8*b +: 8] = wdat[k][8*b +: 8];
          ref_mem[a] = w;
        end else begin
          rd = (k < rdq.size()) ? rdq[k] : 32'hXXXX_XXXX;
          chk($sformatf("%s_rd%0d", tag, k), rd, ref_rd(a));
        end
      end
      chk({tag, "_nacc"}, 32'(acc_log.size()), 32'(ai));
    end
  endtask

  initial begin
    int busy_n;
    logic [31:0] adr;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_adr = 0;
    i_wb_dat = 0; i_wb_sel = 0; i_wb_cti = 0; i_wb_bte = 0;
    for (int k = 0; k < 16; k++) begin wdat[k] = '0; wsel[k] = 4'hF; end
    repeat (3) @(negedge sys_clk);
    chk("rst_ack", 32'(o_wb_ack), 32'd0);
    chk("rst_err", 32'(o_wb_err), 32'd0);
    chk("rst_dat", o_wb_dat, 32'd0);
    chk("rst_rdwr", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_be_wd", mem_wdata | 32'(mem_be), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    reset_n = 1'b1;

    // Single read, three stalled cycles.
    wait_cfg = 3;
    dev_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    rd_hi = 0;
    run_check("rd1", 32'h100, 1'b0, 1, 1'b0, BTE_LINEAR);
    chk("rd1_lat", 32'(lat_first), 32'd5);
    chk("rd1_rdhi", 32'(rd_hi), 32'd4);
    chk("rd1_val", (rdq.size() > 0) ? rdq[0] : 32'h0, 32'hDEAD_BEEF);

    // Partial write, zero wait, then a write with no lanes.
    wait_cfg = 0;
    wdat[0] = 32'h1234_5678; wsel[0] = 4'b0011; wr_hi = 0;
    run_check("wr1", 32'h8, 1'b1, 1, 1'b0, BTE_LINEAR);
    chk("wr1_lat", 32'(lat_first), 32'd2);
    chk("wr1_wrhi", 32'(wr_hi), 32'd1);
    wsel[0] = 4'b0000; wr_hi = 0;
    run_check("wr0", 32'h10, 1'b1, 1, 1'b0, BTE_LINEAR);
    chk("wr0_wrhi", 32'(wr_hi), 32'd0);

    // 4-beat wrapping read burst.
    run_check("wrap4", 32'hC, 1'b0, 4, 1'b1, BTE_WRAP4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("wrap4_seq%0d", k), (k < acc_log.size()) ? acc_log[k].addr : 32'hFFFF_FFFF, wrap_seq[k]);
    chk("wrap4_last", 32'(lat_last), 32'd8);
    chk("wrap4_idle", 32'(o_busy), 32'd0);

    // Out-of-region access.
    rd_hi = 0; wr_hi = 0;
    run_check("miss", 32'h0330_0000, 1'b0, 1, 1'b0, BTE_LINEAR);
    chk("miss_lat", 32'(lat_err), 32'd1);
    chk("miss_req", 32'(rd_hi + wr_hi), 32'd0);

    // Memory never answers.
    wait_cfg = 100000; rd_hi = 0;
    acc_log.delete();
    wb_xfer(32'h40, 1'b0, 1, 1'b0, BTE_LINEAR);
    chk("tmo_err", 32'(errs), 32'd1);
    chk("tmo_ack", 32'(acks), 32'd0);
    chk("tmo_lat", 32'(lat_err), 32'd257);
    chk("tmo_rdhi", 32'(rd_hi), 32'd256);
    chk("tmo_nacc", 32'(acc_log.size()), 32'd0);
    chk("tmo_idle", 32'(o_busy), 32'd0);

    // cyc dropped while the read is outstanding.
    wait_cfg = 5; rd_hi = 0; busy_n = 0; acks = 0; errs = 0;
    @(negedge sys_clk);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_adr = 32'h200; i_wb_cti = CTI_CLASSIC; i_wb_sel = 4'hF;
    for (int t = 1; t <= 20; t++) begin
      @(negedge sys_clk);
      if (o_busy) busy_n++;
      if (o_wb_ack) acks++;
      if (o_wb_err) errs++;
      if (t == 2) begin i_wb_cyc = 0; i_wb_stb = 0; end
    end
    chk("abort_resp", 32'(acks + errs), 32'd0);
    chk("abort_rdhi", 32'(rd_hi), 32'd6);
    chk("abort_busy", 32'(busy_n), 32'd7);

    // Asynchronous reset in the middle of a request.
    wait_cfg = 1000;
    @(negedge sys_clk);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_adr = 32'h300;
    repeat (3) @(negedge sys_clk);
    chk("arst_pre_rd", 32'(mem_rd), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rd", 32'(mem_rd), 32'd0);
    chk("arst_outs", o_wb_dat | mem_addr | mem_wdata | 32'(mem_be) |
        32'({o_wb_ack, o_wb_err, mem_wr, o_busy}), 32'd0);
    i_wb_cyc = 0; i_wb_stb = 0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    wait_cfg = 0;

    // Random traffic with random memory stalls.
    wait_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int          r, n;
      bit          we, burst;
      logic [1:0]  bte;
      r = $urandom_range(0, 9);
      adr = 32'($urandom_range(0, 255)) << 2;
      if (r == 0) adr = 32'h0020_0000 | (32'($urandom_range(0, 1023)) << 2);
      we = 1'($urandom_range(0, 1));
      burst = (r >= 5);
      bte = burst ? 2'($urandom_range(0, 3)) : BTE_LINEAR;
      n = !burst ? 1 : (bte == BTE_LINEAR ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 2 << bte)));
      for (int k = 0; k < 16; k++) begin
        wdat[k] = $urandom;
        wsel[k] = 4'($urandom_range(0, 15));
      end
      run_check($sformatf("rnd%0d", i), adr, we, n, burst, bte);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
